// File: rtl/mem_arbiter.sv
// Byte-wide memory port arbiter between instruction fetch and the load/store buffer.
// Optional `MEM_ARB_IO_EN adds io_full back-pressure for stores into IO space (addr[17:16]==2'b11).
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr
`ifdef MEM_ARB_IO_EN
    ,
    input  logic              io_full
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        nbytes;
    logic [2:0]        cnt;
    logic              is_if;
    logic [31:0]       wdata;
    logic [31:0]       asm_q;
    logic [31:0]       asm_next;
    logic [3:0]        starve;
    logic [2:0]        ls_n;
    logic [1:0]        rd_idx;
    logic [1:0]        wr_idx;
    logic              grant_ls;
    logic              grant_if;
    logic              io_blk_grant;
    logic              io_blk;

    // A flush on the arbitration edge only removes IF from contention.
    assign grant_ls = ls_req && !(if_req && !flush && starve == SMAX);
    assign grant_if = if_req && !flush && !grant_ls;

    always_comb begin
        case (ls_size)
            2'd0:    ls_n = 3'd1;
            2'd1:    ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase
    end

`ifdef MEM_ARB_IO_EN
    assign io_blk_grant = ls_we && (ls_addr[17:16] == 2'b11) && io_full;
    assign io_blk       = (addr[17:16] == 2'b11) && io_full;
`else
    assign io_blk_grant = 1'b0;
    assign io_blk       = 1'b0;
`endif

    // Byte issued in cycle k returns one cycle later, so the byte landing now is cnt-1.
    assign rd_idx = cnt[1:0] - 2'd1;
    assign wr_idx = cnt[1:0] + 2'd1;

    always_comb begin
        asm_next = asm_q;
        asm_next[{rd_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            nbytes   <= '0;
            cnt      <= '0;
            is_if    <= 1'b0;
            wdata    <= '0;
            asm_q    <= '0;
            starve   <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    asm_q <= '0;
                    if (grant_ls) begin
                        is_if    <= 1'b0;
                        addr     <= ls_addr;
                        mem_a    <= ls_addr;
                        nbytes   <= ls_n;
                        wdata    <= ls_wdata;
                        mem_dout <= ls_wdata[7:0];
                        if (ls_we) begin
                            state  <= WR;
                            mem_wr <= !io_blk_grant;
                        end else begin
                            state <= RD;
                        end
                        if (!if_req)             starve <= '0;
                        else if (starve != SMAX) starve <= starve + 4'd1;
                    end else if (grant_if) begin
                        is_if  <= 1'b1;
                        addr   <= if_addr;
                        mem_a  <= if_addr;
                        nbytes <= 3'd4;
                        state  <= RD;
                        starve <= '0;
                    end
                end
                RD: begin
                    if (flush && is_if) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt != 3'd0) asm_q <= asm_next;
                        if (cnt == nbytes) begin
                            state <= DONE;
                            if (is_if) begin
                                if_done <= 1'b1;
                                if_data <= asm_next;
                            end else begin
                                ls_done  <= 1'b1;
                                ls_rdata <= asm_next;
                            end
                        end else if (cnt + 3'd1 < nbytes) begin
                            mem_a <= addr + ADDR_W'(cnt) + ADDR_W'(1);
                        end
                    end
                end
                WR: begin
                    // mem_wr low means this cycle was stalled; the same byte is retried.
                    if (mem_wr) begin
                        if (cnt + 3'd1 == nbytes) begin
                            state   <= DONE;
                            mem_wr  <= 1'b0;
                            ls_done <= 1'b1;
                        end else begin
                            cnt      <= cnt + 3'd1;
                            mem_a    <= addr + ADDR_W'(cnt) + ADDR_W'(1);
                            mem_dout <= wdata[{wr_idx, 3'b000} +: 8];
                            mem_wr   <= !io_blk;
                        end
                    end else begin
                        mem_wr <= !io_blk;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
